// File: rtl/ddr3_udp_reader.sv
// ddr3_udp_reader: reads one packet payload out of DDR3 as 128-bit beats and
// serializes it byte by byte into a UDP transmitter. Reads run ahead of the
// UDP side through a 2-entry beat buffer, limited to two beats in flight.
module ddr3_udp_reader (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [27:0]  i_base_addr,
    input  logic [15:0]  i_byte_len,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_underrun,
    output logic [2:0]   o_ddr3_cmd,
    output logic         o_ddr3_cmd_en,
    output logic [27:0]  o_ddr3_addr,
    input  logic         i_ddr3_cmd_ready,
    input  logic [127:0] i_ddr3_rd_data,
    input  logic         i_ddr3_rd_data_de,
    output logic         o_udp_tx_en,
    output logic         o_udp_tx_de,
    output logic [7:0]   o_udp_data,
    output logic [15:0]  o_udp_datalen,
    output logic [15:0]  o_ipv4_sign,
    input  logic         i_udp_busy,
    input  logic         i_udp_isLoadData,
    input  logic         i_udp_1Byte_pass
);

    typedef enum logic [1:0] {IDLE, WAIT_UDP, STREAM, DONE} state_t;

    state_t        state;
    logic [27:0]   rd_addr;
    logic [15:0]   pkt_len;
    logic [6:0]    beats_left;
    logic [1:0]    outstanding;
    logic [127:0]  fifo_mem [2];
    logic          fifo_wr_ptr;
    logic          fifo_rd_ptr;
    logic [1:0]    fifo_count;
    logic [15:0]   byte_idx;

    logic          active;
    logic          start_ok;
    logic          issue;
    logic          rd_accept;
    logic          tx_de;
    logic          advance;
    logic          last_byte;
    logic          pop;
    logic [127:0]  head;

    assign active    = (state == WAIT_UDP) || (state == STREAM);
    assign start_ok  = (state == IDLE) && i_start &&
                       (i_byte_len != 16'd0) && (i_byte_len <= 16'd1472);
    // Beats in flight plus beats buffered never exceed the 2-entry buffer.
    assign issue     = i_ddr3_cmd_ready && (beats_left != 7'd0) &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2);
    assign rd_accept = i_ddr3_rd_data_de && (outstanding != 2'd0);
    assign head      = fifo_mem[fifo_rd_ptr];
    assign tx_de     = active && (fifo_count != 2'd0) && (byte_idx < pkt_len);
    assign advance   = (state == STREAM) && tx_de && i_udp_isLoadData && i_udp_1Byte_pass;
    assign last_byte = (16'(byte_idx + 16'd1) == pkt_len);
    // Popping on the last byte drops the unused tail of the final beat.
    assign pop       = advance && ((byte_idx[3:0] == 4'hF) || last_byte);

    assign o_ddr3_cmd_en = issue;
    assign o_ddr3_cmd    = issue ? 3'b001 : '0;
    assign o_ddr3_addr   = rd_addr;
    assign o_udp_tx_en   = (state == WAIT_UDP) && !i_udp_busy;
    assign o_udp_tx_de   = tx_de;
    assign o_udp_data    = tx_de ? head[{byte_idx[3:0], 3'b000} +: 8] : '0;
    assign o_udp_datalen = pkt_len;

    // Packet control FSM: acceptance, UDP request, byte counting, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_underrun  <= 1'b0;
            o_ipv4_sign <= '0;
            pkt_len     <= '0;
            byte_idx    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pkt_len    <= i_byte_len;
                        byte_idx   <= '0;
                        o_busy     <= 1'b1;
                        o_underrun <= 1'b0;
                        state      <= WAIT_UDP;
                    end
                end
                WAIT_UDP: begin
                    if (!i_udp_busy)
                        state <= STREAM;
                end
                STREAM: begin
                    if (i_udp_1Byte_pass && !tx_de)
                        o_underrun <= 1'b1;
                    if (advance) begin
                        byte_idx <= byte_idx + 16'd1;
                        if (last_byte) begin
                            state       <= DONE;
                            o_done      <= 1'b1;
                            o_ipv4_sign <= o_ipv4_sign + 16'd1;
                        end
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read command issue: address/beat bookkeeping and in-flight count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr     <= '0;
            beats_left  <= '0;
            outstanding <= '0;
        end else begin
            if (start_ok) begin
                rd_addr    <= i_base_addr;
                beats_left <= 7'((i_byte_len + 16'd15) >> 4);
            end else if (issue) begin
                rd_addr    <= rd_addr + 28'd8;
                beats_left <= beats_left - 7'd1;
            end
            case ({issue, rd_accept})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Two-entry beat buffer between read returns and the serializer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++)
                fifo_mem[i] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= '0;
        end else begin
            if (rd_accept) begin
                fifo_mem[fifo_wr_ptr] <= i_ddr3_rd_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({rd_accept, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
